// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter that shares the single register-file write port
// among NUM_REQ requesters, with valid/ready handshake, burst lock and one-cycle registered issue.
//
// Ports:
//   Clk, Rst               clock and synchronous active-high reset
//   req_valid/req_lock     per-requester write pending / keep-port-after-this-beat
//   req_addr/req_data      packed per-requester address and data slices
//   req_ready              one-hot (or zero) accept strobe, combinational
//   rf_stall               blocks every grant this cycle
//   WriteEn/WriteAddr      registered write enable and address to the register file
//   data_o                 registered write data
//   grant_id               index of the requester behind the current beat
//
// Optional feature macro: RF_ZERO_DISCARD_EN
//   When defined, accepted beats to address 0 are handshaken but never raise WriteEn.
module rf_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int Data_WIDTH = 32,
    parameter int Addr_WIDTH = 5,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*Addr_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*Data_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          rf_stall,
    output logic                          WriteEn,
    output logic [Addr_WIDTH-1:0]         WriteAddr,
    output logic [Data_WIDTH-1:0]         data_o,
    output logic [ID_WIDTH-1:0]           grant_id
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic                  we_q, we_d;
    logic [Addr_WIDTH-1:0] waddr_q, waddr_d;
    logic [Data_WIDTH-1:0] wdata_q, wdata_d;
    logic [ID_WIDTH-1:0]   gid_q, gid_d;

    logic                  found;
    logic [ID_WIDTH-1:0]   win;
    logic [ID_WIDTH-1:0]   sel;
    logic                  sel_valid;
    logic                  sel_lock;
    logic [Addr_WIDTH-1:0] sel_addr;
    logic [Data_WIDTH-1:0] sel_data;
    logic                  accept;
    int                    idx;

    function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] g);
        next_ptr = (g == ID_WIDTH'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    endfunction

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == idx) && req_valid[i]) begin
                    found = 1'b1;
                    win   = ID_WIDTH'(i);
                end
            end
        end
    end

    // In LOCKED only the owner is considered; otherwise the scan winner.
    always_comb begin
        sel       = (state_q == LOCKED) ? owner_q : win;
        sel_valid = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == sel) begin
                sel_valid = req_valid[i];
                sel_lock  = req_lock[i];
                sel_addr  = req_addr[i*Addr_WIDTH +: Addr_WIDTH];
                sel_data  = req_data[i*Data_WIDTH +: Data_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (!Rst && !rf_stall && sel_valid) begin
            accept = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ID_WIDTH'(i) == sel) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Next-state logic; a stall freezes state and pointer.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (!rf_stall) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (sel_lock) begin
                            state_d = LOCKED;
                            owner_d = sel;
                        end else begin
                            rr_ptr_d = next_ptr(sel);
                        end
                    end
                end
                LOCKED: begin
                    // Release on the last locked beat, or when the owner
                    // abandons both valid and lock (no beat issued).
                    if (!sel_lock) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr(owner_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
`ifdef RF_ZERO_DISCARD_EN
        we_d    = accept && (sel_addr != '0);
`else
        we_d    = accept;
`endif
        if (accept) begin
            waddr_d = sel_addr;
            wdata_d = sel_data;
            gid_d   = sel;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            gid_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            gid_q    <= gid_d;
        end
    end

    assign WriteEn   = we_q;
    assign WriteAddr = waddr_q;
    assign data_o    = wdata_q;
    assign grant_id  = gid_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed-vector bench for rf_write_arbiter.
// Covers reset, round-robin order, lock bursts, stall, address 0 and reset mid-accept.
module tb_rf_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int IW = 2;

    logic            Clk;
    logic            Rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rf_stall;
    logic            WriteEn;
    logic [AW-1:0]   WriteAddr;
    logic [DW-1:0]   data_o;
    logic [IW-1:0]   grant_id;

    int vectors;
    int miscompares;

    rf_write_arbiter #(
        .NUM_REQ   (N),
        .Data_WIDTH(DW),
        .Addr_WIDTH(AW),
        .ID_WIDTH  (IW)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .req_valid(req_valid),
        .req_lock (req_lock),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ready(req_ready),
        .rf_stall (rf_stall),
        .WriteEn  (WriteEn),
        .WriteAddr(WriteAddr),
        .data_o   (data_o),
        .grant_id (grant_id)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic chk_beat(input string tag, input int id,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, "_we"}, 64'(WriteEn), 64'd1);
        chk({tag, "_id"}, 64'(grant_id), 64'(id));
        chk({tag, "_addr"}, 64'(WriteAddr), 64'(a));
        chk({tag, "_data"}, 64'(data_o), 64'(d));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst         = 1'b1;
        rf_stall    = 1'b0;
        req_valid   = 4'b1111;
        req_lock    = 4'b0000;
        req_addr    = '0;
        req_data    = '0;
        for (int i = 0; i < N; i++) begin
            set_req(i, AW'(10 + i), DW'(32'h1000 + i));
        end

        // Reset held two cycles with every requester valid
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_we", 64'(WriteEn), 64'd0);
            chk("rst_addr", 64'(WriteAddr), 64'd0);
            chk("rst_data", 64'(data_o), 64'd0);
            chk("rst_gid", 64'(grant_id), 64'd0);
        end
        Rst = 1'b0;
        #1;

        // Round robin 0,1,2,3 with back-to-back issue
        for (int i = 0; i < N; i++) begin
            chk("rr_ready", 64'(req_ready), 64'(4'b0001 << i));
            step();
            chk_beat("rr", i, AW'(10 + i), DW'(32'h1000 + i));
        end
        // Pointer wrapped 3 -> 0
        chk("wrap_ready", 64'(req_ready), 64'b0001);
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd0);
        step();
        chk("idle_we", 64'(WriteEn), 64'd0);
        chk("hold_addr", 64'(WriteAddr), 64'd13);
        chk("hold_gid", 64'(grant_id), 64'd3);

        // Lock burst from requester 2, with a bubble mid-burst
        req_valid = 4'b0100;
        req_lock  = 4'b0100;
        set_req(2, 5'd7, 32'hA5A5_0001);
        #1;
        chk("lk1_ready", 64'(req_ready), 64'b0100);
        step();
        chk_beat("lk1", 2, 5'd7, 32'hA5A5_0001);
        req_valid = 4'b0101;
        set_req(2, 5'd7, 32'hA5A5_0002);
        #1;
        chk("lk2_ready", 64'(req_ready), 64'b0100);
        step();
        chk_beat("lk2", 2, 5'd7, 32'hA5A5_0002);
        req_valid = 4'b0001;
        #1;
        chk("bubble_ready", 64'(req_ready), 64'b0000);
        step();
        chk("bubble_we", 64'(WriteEn), 64'd0);
        req_valid = 4'b0101;
        req_lock  = 4'b0000;
        set_req(2, 5'd7, 32'hA5A5_0003);
        #1;
        chk("lk3_ready", 64'(req_ready), 64'b0100);
        step();
        chk_beat("lk3", 2, 5'd7, 32'hA5A5_0003);
        req_valid = 4'b0001;
        #1;
        chk("unlk_ready", 64'(req_ready), 64'b0001);
        step();
        chk_beat("unlk", 0, 5'd10, 32'h1000);

        // Stall two cycles, pointer now at 1
        req_valid = 4'b0011;
        rf_stall  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("stall_ready", 64'(req_ready), 64'd0);
            step();
            chk("stall_we", 64'(WriteEn), 64'd0);
        end
        rf_stall = 1'b0;
        #1;
        chk("post_stall_ready", 64'(req_ready), 64'b0010);
        step();
        chk_beat("post_stall", 1, 5'd11, 32'h1001);
        req_valid = 4'b0001;
        #1;
        chk("after_ready", 64'(req_ready), 64'b0001);
        step();
        chk_beat("after", 0, 5'd10, 32'h1000);

        // Address 0 beat from requester 1 (pointer at 1)
        req_valid = 4'b0010;
        set_req(1, 5'd0, 32'hDEAD_BEEF);
        #1;
        chk("z_ready", 64'(req_ready), 64'b0010);
        step();
`ifdef RF_ZERO_DISCARD_EN
        chk("z_we", 64'(WriteEn), 64'd0);
`else
        chk("z_we", 64'(WriteEn), 64'd1);
`endif
        chk("z_addr", 64'(WriteAddr), 64'd0);
        chk("z_data", 64'(data_o), 64'hDEAD_BEEF);
        chk("z_gid", 64'(grant_id), 64'd1);

        // Requester 3 (addr 31) while reset asserted on the same edge
        req_valid = 4'b1000;
        set_req(3, 5'd31, 32'h3333_3333);
        #1;
        chk("r6_ready", 64'(req_ready), 64'b1000);
        Rst = 1'b1;
        #1;
        chk("r6_rst_ready", 64'(req_ready), 64'd0);
        step();
        chk("r6_we", 64'(WriteEn), 64'd0);
        chk("r6_addr", 64'(WriteAddr), 64'd0);
        Rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("r6_ptr", 64'(req_ready), 64'b0001);
        step();
        chk_beat("r6_first", 0, 5'd10, 32'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
